// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the async FIFO and its read-side blocks
package fifo_pkg;
  localparam int FIFO_RD_LAT = 1;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry register FIFO presenting its oldest word as a valid/ready stream
module stream_skid_buf #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;
  always_comb begin
    pop    = (occ_q != 2'd0) & out_ready;
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    // head refills from tail when it drains a full buffer, else straight from the pushed word
    head_d = (pop & (occ_q == 2'd2)) ? tail_q :
             (push & ((occ_q == 2'd0) | (pop & (occ_q == 2'd1)))) ? push_data : head_q;
    tail_d = (push & (((occ_q == 2'd1) & ~pop) | (occ_q == 2'd2))) ? push_data : tail_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end
  assign out_valid = occ_q != 2'd0;
  assign out_data  = head_q;
  assign occ       = occ_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains the async FIFO read port into a framed valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 3,
  parameter int FRAME_LEN = 8,
  localparam int BEAT_W   = idx_w(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              frame_done
);
  logic [FIFO_RD_LAT-1:0] inflight_q, inflight_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic                   frame_done_q, frame_done_d;
  logic [1:0]             occ;
  logic                   pop, last;
  int                     pend;
  stream_skid_buf #(.W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q[FIFO_RD_LAT-1]),
    .push_data (fifo_rd_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occ       (occ)
  );
  always_comb begin
    pop          = out_valid & out_ready;
    last         = out_valid & (beat_q == BEAT_W'(FRAME_LEN - 1));
    // words already owed to the buffer count against its two slots
    pend         = int'(occ) + $countones(inflight_q) - int'(pop);
    fifo_r_en    = ~rst & en & ~fifo_empty & (pend < 2);
    inflight_d   = FIFO_RD_LAT'({inflight_q, fifo_r_en});
    beat_d       = pop ? (last ? '0 : beat_q + 1'b1) : beat_q;
    frame_done_d = pop & last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q   <= '0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign out_last   = last;
  assign beat_idx   = beat_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomised checks of the FIFO drain stream against a scoreboard
module tb_fifo_stream_reader;
  localparam int DW = 3;
  localparam int FL = 8;
  localparam int BW = 3;
  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, fifo_empty = 1'b1, out_ready = 1'b0, gap = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_r_en, out_valid, out_last, frame_done;
  logic [DW-1:0] out_data;
  logic [BW-1:0] beat_idx;
  int            errors = 0, checks = 0;
  logic [DW-1:0] src[$], exp_q[$];
  int            exp_beat = 0, lasts = 0, dones = 0;
  logic          prev_stall = 1'b0, prev_pl = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .FRAME_LEN(FL)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_r_en    (fifo_r_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .beat_idx     (beat_idx),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_w(input logic [DW-1:0] v);
    src.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src.delete();
    exp_q.delete();
    gap = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (exp_q.size() == 0 && !out_valid && src.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // FIFO read port model: one-cycle read latency, empty flag updated on the clock
  always @(posedge clk) begin
    if (rst) fifo_empty <= 1'b1;
    else begin
      if (fifo_r_en) fifo_rd_data <= src.pop_front();
      fifo_empty <= (src.size() == 0) | gap;
    end
  end

  // stream monitor: ordering, stall stability, beat/last/frame_done tracking
  always @(negedge clk) begin
    if (rst) begin
      exp_beat   = 0;
      prev_stall = 1'b0;
      prev_pl    = 1'b0;
    end else begin
      chk("frame_done", frame_done, prev_pl);
      if (frame_done) dones++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      chk("beat_idx", beat_idx, exp_beat);
      chk("out_last", out_last, out_valid && exp_beat == FL - 1);
      prev_pl = out_valid & out_ready & out_last;
      if (out_valid & out_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else chk("data", out_data, exp_q.pop_front());
        if (out_last) lasts++;
        exp_beat = (exp_beat == FL - 1) ? 0 : exp_beat + 1;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, reads, sent;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_beat", beat_idx, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ren", fifo_r_en, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // T1: latency and back-to-back delivery
    push_w(3'd5); push_w(3'd2); push_w(3'd7);
    en = 1'b1; out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_r_en) begin found = 1; break; end
    end
    chk("t1_ren_seen", found, 1);
    chk("t1_valid_n0", out_valid, 0);
    @(negedge clk); chk("t1_valid_n1", out_valid, 0);
    @(negedge clk); chk("t1_valid_n2", out_valid, 1); chk("t1_w0", out_data, 5);
    @(negedge clk); chk("t1_valid_n3", out_valid, 1); chk("t1_w1", out_data, 2);
    @(negedge clk); chk("t1_valid_n4", out_valid, 1); chk("t1_w2", out_data, 7);
    wait_drain(20);
    // T2: two full frames
    do_reset();
    lasts = 0; dones = 0;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_w(DW'(i * 3));
    wait_drain(60);
    @(negedge clk);
    chk("t2_lasts", lasts, 2);
    chk("t2_dones", dones, 2);
    chk("t2_beat", beat_idx, 0);
    // T3: backpressure stops reads after two
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_w(DW'(i));
    reads = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_r_en) reads++;
    end
    chk("t3_reads", reads, 2);
    chk("t3_occ", u_dut.occ, 2);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_data, 0);
    tick(); out_ready = 1'b1;
    wait_drain(60);
    // T4: random backpressure and empty gaps
    do_reset();
    en = 1'b1;
    sent = 0;
    for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() > 0); c++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 3) == 0);
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        push_w(DW'($urandom_range(0, 7)));
        sent++;
      end
    end
    chk("t4_sent", sent, 1000);
    tick(); out_ready = 1'b1; gap = 1'b0;
    wait_drain(60);
    // T5: en dropped with one buffered and one in flight
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_w(DW'(i));
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_r_en) begin found = 1; break; end
    end
    chk("t5_ren_seen", found, 1);
    tick(); tick(); en = 1'b0;
    @(negedge clk);
    chk("t5_occ", u_dut.occ, 1);
    chk("t5_inflight", u_dut.inflight_q[0], 1);
    tick(); out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_read", fifo_r_en, 0);
    end
    chk("t5_beat_hold", beat_idx, 2);
    chk("t5_fifo_left", src.size(), 3);
    chk("t5_valid_off", out_valid, 0);
    tick(); en = 1'b1;
    wait_drain(40);
    // T6: asynchronous reset mid-frame
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_w(DW'(i));
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && beat_idx == 3'd3) begin found = 1; break; end
    end
    chk("t6_mid_frame", found, 1);
    #2 rst = 1'b1;
    src.delete(); exp_q.delete();
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_last", out_last, 0);
    chk("t6_beat", beat_idx, 0);
    chk("t6_done", frame_done, 0);
    chk("t6_ren", fifo_r_en, 0);
    tick(); tick(); rst = 1'b0;
    push_w(3'd4); push_w(3'd6);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1; break; end
    end
    chk("t6_restart", found, 1);
    chk("t6_new_beat", beat_idx, 0);
    chk("t6_new_word", out_data, 4);
    wait_drain(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
